// File: rtl/seq_tracker.sv
// seq_tracker
//    Watches a 4-bit code stream and locates it within a programmed N-step
//    sequence. After LOCK_N consecutive in-order codes it locks. While locked it
//    keeps advancing the position on every valid code (flywheel), flags each
//    out-of-sequence code and counts it. LOSS_N consecutive misses drop the lock.
//
//    state  | meaning
//    -------+-----------------------------------------------------------
//    HUNT   | no position known; any table code seeds the position
//    VERIFY | position seeded; counting in-order codes toward lock
//    LOCKED | tracking; misses pulse err_o and count, position flywheels
//
// Ports
//    clk_i     clock, rising edge
//    rst_i     synchronous active-high reset, overrides valid_i
//    valid_i   d_i valid; when low all state holds and err_o is 0
//    d_i       incoming 4-bit code
//    idx_o     index of the last accepted code
//    nxt_o     expected next code, table entry (idx_o+1) mod LEN
//    lock_o    high while LOCKED
//    err_o     one-cycle pulse on a mismatch while LOCKED
//    errcnt_o  mismatches while LOCKED, saturates at 255
module seq_tracker #(
   parameter logic [31:0] SEQ    = 32'hFA06C953,
   parameter int          LEN    = 8,
   parameter int          LOCK_N = 3,
   parameter int          LOSS_N = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       valid_i,
   input  logic [3:0] d_i,
   output logic [2:0] idx_o,
   output logic [3:0] nxt_o,
   output logic       lock_o,
   output logic       err_o,
   output logic [7:0] errcnt_o
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [2:0] LAST   = 3'(LEN - 1);
   localparam logic [2:0] LOCK_W = 3'(LOCK_N);
   localparam logic [2:0] LOSS_W = 3'(LOSS_N);

   function automatic logic [3:0] entry(input logic [2:0] k);
      return SEQ[{k, 2'b00} +: 4];
   endfunction

   function automatic logic [2:0] inc(input logic [2:0] i);
      return (i == LAST) ? 3'd0 : i + 3'd1;
   endfunction

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] nxt_q, nxt_d;
   logic [2:0] hits_q, hits_d;
   logic [2:0] miss_q, miss_d;
   logic       err_q, err_d;
   logic [7:0] errcnt_q, errcnt_d;

   logic       hunt_hit;
   logic [2:0] hunt_idx;

   // Scan from the top down so the lowest matching index wins on duplicates.
   always_comb begin
      hunt_hit = 1'b0;
      hunt_idx = 3'd0;
      for (int k = LEN - 1; k >= 0; k--) begin
         if (entry(3'(k)) == d_i) begin
            hunt_hit = 1'b1;
            hunt_idx = 3'(k);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      hits_d   = hits_q;
      miss_d   = miss_q;
      err_d    = 1'b0;
      errcnt_d = errcnt_q;

      if (valid_i) begin
         unique case (state_q)
            HUNT: begin
               if (hunt_hit) begin
                  idx_d   = hunt_idx;
                  hits_d  = 3'd1;
                  state_d = VERIFY;
               end
            end
            VERIFY: begin
               if (d_i == nxt_q) begin
                  idx_d  = inc(idx_q);
                  hits_d = hits_q + 3'd1;
                  if (hits_q + 3'd1 >= LOCK_W) begin
                     state_d = LOCKED;
                     miss_d  = 3'd0;
                  end
               end else if (hunt_hit) begin
                  idx_d  = hunt_idx;
                  hits_d = 3'd1;
               end else begin
                  hits_d  = 3'd0;
                  state_d = HUNT;
               end
            end
            LOCKED: begin
               // Position advances on every valid code, hit or miss.
               idx_d = inc(idx_q);
               if (d_i == nxt_q) begin
                  miss_d = 3'd0;
               end else begin
                  err_d = 1'b1;
                  if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                  if (miss_q + 3'd1 >= LOSS_W) begin
                     miss_d  = 3'd0;
                     hits_d  = 3'd0;
                     state_d = HUNT;
                  end else begin
                     miss_d = miss_q + 3'd1;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      nxt_d = entry(inc(idx_d));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= HUNT;
         idx_q    <= 3'd0;
         nxt_q    <= entry(inc(3'd0));
         hits_q   <= 3'd0;
         miss_q   <= 3'd0;
         err_q    <= 1'b0;
         errcnt_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         nxt_q    <= nxt_d;
         hits_q   <= hits_d;
         miss_q   <= miss_d;
         err_q    <= err_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign idx_o    = idx_q;
   assign nxt_o    = nxt_q;
   assign lock_o   = (state_q == LOCKED);
   assign err_o    = err_q;
   assign errcnt_o = errcnt_q;

endmodule
